// File: rtl/mem_stage.sv
// mem_stage: load/store unit between execute and write-back.
// Single outstanding req/ack transaction; stalls EX while it is in flight.
module mem_stage (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        EX_Mem_wr_en,
  input  logic        EX_Mem_rd_en,
  input  logic [2:0]  EX_Mem_op,
  input  logic [31:0] EX_Rs2_data,
  input  logic [31:0] EX_ALU_result,
  input  logic        EX_MemToReg,
  input  logic        EX_RegFile_wr_en,
  input  logic [4:0]  EX_Rd_addr,
  output logic        MEM_Stall,
  output logic        DMem_req,
  output logic        DMem_we,
  output logic [31:0] DMem_addr,
  output logic [3:0]  DMem_be,
  output logic [31:0] DMem_wdata,
  input  logic        DMem_ack,
  input  logic [31:0] DMem_rdata,
  output logic        MEM_RegFile_wr_en,
  output logic [4:0]  MEM_Rd_addr,
  output logic        MEM_MemToReg,
  output logic [31:0] MEM_ALU_result,
  output logic [31:0] MEM_Load_data,
  output logic        MEM_Misaligned
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_nxt;
  logic        access, is_byte, is_half;
  logic        misaligned, capture, done;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] shifted, load_ext;

  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic        req_load;
  logic        req_rf_wr_en;
  logic [4:0]  req_rd;
  logic        req_m2r;

  assign access  = EX_Mem_wr_en | EX_Mem_rd_en;
  assign is_byte = (EX_Mem_op[1:0] == 2'b00);
  assign is_half = (EX_Mem_op[1:0] == 2'b01);

  assign misaligned = access &
    ((is_half & EX_ALU_result[0]) |
     (~is_byte & ~is_half &
      (EX_ALU_result[1:0] != 2'b00)));

  assign capture = (state == IDLE) & access
                 & ~misaligned;
  assign done = (state == WAIT) & DMem_ack;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (capture)  state_nxt = WAIT;
      WAIT: if (DMem_ack) state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  always_comb begin
    MEM_Stall = ~Reset &
      (capture | ((state == WAIT) & ~DMem_ack));
  end

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = EX_Rs2_data;
    unique case (1'b1)
      is_byte: begin
        be_nxt    = 4'b0001 << EX_ALU_result[1:0];
        wdata_nxt = {4{EX_Rs2_data[7:0]}};
      end
      is_half: begin
        be_nxt    = 4'b0011 << EX_ALU_result[1:0];
        wdata_nxt = {2{EX_Rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted  = DMem_rdata >> {req_addr[1:0], 3'b000};
    load_ext = shifted;
    case (req_op)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Bus fields hold after ack; only req drops.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      DMem_req     <= 1'b0;
      DMem_we      <= 1'b0;
      DMem_addr    <= 32'd0;
      DMem_be      <= 4'd0;
      DMem_wdata   <= 32'd0;
      req_op       <= 3'd0;
      req_addr     <= 32'd0;
      req_load     <= 1'b0;
      req_rf_wr_en <= 1'b0;
      req_rd       <= 5'd0;
      req_m2r      <= 1'b0;
    end else if (capture) begin
      DMem_req     <= 1'b1;
      DMem_we      <= EX_Mem_wr_en;
      DMem_addr    <= {EX_ALU_result[31:2], 2'b00};
      DMem_be      <= be_nxt;
      DMem_wdata   <= wdata_nxt;
      req_op       <= EX_Mem_op;
      req_addr     <= EX_ALU_result;
      req_load     <= EX_Mem_rd_en & ~EX_Mem_wr_en;
      req_rf_wr_en <= EX_RegFile_wr_en;
      req_rd       <= EX_Rd_addr;
      req_m2r      <= EX_MemToReg;
    end else if (done) begin
      DMem_req     <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      MEM_RegFile_wr_en <= 1'b0;
      MEM_Rd_addr       <= 5'd0;
      MEM_MemToReg      <= 1'b0;
      MEM_ALU_result    <= 32'd0;
      MEM_Load_data     <= 32'd0;
      MEM_Misaligned    <= 1'b0;
    end else if (done) begin
      MEM_RegFile_wr_en <= req_rf_wr_en;
      MEM_Rd_addr       <= req_rd;
      MEM_MemToReg      <= req_m2r;
      MEM_ALU_result    <= req_addr;
      MEM_Load_data     <= req_load ? load_ext
                                    : 32'd0;
      MEM_Misaligned    <= 1'b0;
    end else if (state == IDLE && !access) begin
      MEM_RegFile_wr_en <= EX_RegFile_wr_en;
      MEM_Rd_addr       <= EX_Rd_addr;
      MEM_MemToReg      <= EX_MemToReg;
      MEM_ALU_result    <= EX_ALU_result;
      MEM_Load_data     <= 32'd0;
      MEM_Misaligned    <= 1'b0;
    end else begin
      MEM_RegFile_wr_en <= 1'b0;
      MEM_Rd_addr       <= 5'd0;
      MEM_MemToReg      <= 1'b0;
      MEM_ALU_result    <= 32'd0;
      MEM_Load_data     <= 32'd0;
      MEM_Misaligned    <= (state == IDLE) & misaligned;
    end
  end

endmodule
